m_4to8_loader: RTL and testbench



---
 rtl/m_4to8_loader_pkg.sv | 20 ++
 rtl/m_4to8_loader_sorted_insert.sv | 36 +++
 rtl/m_4to8_loader.sv | 116 +++++++++++
 tb/tb_m_4to8_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/m_4to8_loader_pkg.sv
// Shared constants for the 4-to-8 merge front-end loader: state codes,
// load pulse codes and the fill counter width helper.
package m_4to8_loader_pkg;

   localparam logic [2:0] FILL_A = 3'd0;
   localparam logic [2:0] LOAD_A = 3'd1;
   localparam logic [2:0] FILL_B = 3'd2;
   localparam logic [2:0] LOAD_B = 3'd3;
   localparam logic [2:0] WAIT   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam logic [1:0] LOAD_A_CODE = 2'b01;
   localparam logic [1:0] LOAD_B_CODE = 2'b10;

   // Fill counter width; a single-key half still needs one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/m_4to8_loader_sorted_insert.sv
// Combinational insertion of one key into the ascending prefix (first cnt
// slots) of a packed N-key half; equal keys keep arrival order.
module m_4to8_loader_sorted_insert
   import m_4to8_loader_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic [N*WIDTH-1:0]    half,
   input  logic [cnt_w(N)-1:0]   cnt,
   input  logic [WIDTH-1:0]      key,
   output logic [N*WIDTH-1:0]    half_ins
);

   localparam int CW = cnt_w(N);

   // stay[k]: slot k is a valid entry not greater than the key, so it keeps its place.
   logic [N-1:0] stay;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slot
         localparam logic [CW-1:0] IDX = CW'(gi);
         assign stay[gi] = (IDX < cnt) && (half[gi*WIDTH +: WIDTH] <= key);
         if (gi == 0) begin : g_first
            assign half_ins[gi*WIDTH +: WIDTH] = stay[gi] ? half[gi*WIDTH +: WIDTH] : key;
         end else begin : g_rest
            assign half_ins[gi*WIDTH +: WIDTH] =
               stay[gi]   ? half[gi*WIDTH +: WIDTH] :
               stay[gi-1] ? key :
                            half[(gi-1)*WIDTH +: WIDTH];
         end
      end
   endgenerate

endmodule

// File: rtl/m_4to8_loader.sv
// Loader for the 4-to-8 merger: sorts two N-key halves from a serial stream,
// pulses load[0]/load[1], then flags merged_valid after the merger latency.
module m_4to8_loader
   import m_4to8_loader_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int N         = 4,
   parameter int MERGE_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [1:0]           load,
   output logic [2*N*WIDTH-1:0] inba,
   output logic                 merged_valid
);

   localparam int CW = cnt_w(N);

   logic [2:0]         state_reg, state_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [3:0]         wait_reg, wait_next;
   logic [N*WIDTH-1:0] a_reg, a_next;
   logic [N*WIDTH-1:0] b_reg, b_next;
   logic [1:0]         load_reg, load_next;
   logic               mv_reg, mv_next;

   logic [N*WIDTH-1:0] half_sel;
   logic [N*WIDTH-1:0] half_ins;
   logic               accept;

   assign in_ready     = (state_reg == FILL_A) || (state_reg == FILL_B);
   assign accept       = in_valid && in_ready;
   assign half_sel     = (state_reg == FILL_B) ? b_reg : a_reg;
   assign inba         = {b_reg, a_reg};
   assign load         = load_reg;
   assign merged_valid = mv_reg;

   m_4to8_loader_sorted_insert #(
      .WIDTH (WIDTH),
      .N     (N)
   ) u_insert (
      .half     (half_sel),
      .cnt      (cnt_reg),
      .key      (in_data),
      .half_ins (half_ins)
   );

   // Pulses are set on the transition edge so they line up with the LOAD/DONE cycle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      wait_next  = wait_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      load_next  = 2'b00;
      mv_next    = 1'b0;
      case (state_reg)
         FILL_A, FILL_B: begin
            if (accept) begin
               if (state_reg == FILL_A) a_next = half_ins;
               else                     b_next = half_ins;
               if (cnt_reg == CW'(N - 1)) begin
                  cnt_next = '0;
                  if (state_reg == FILL_A) begin
                     state_next = LOAD_A;
                     load_next  = LOAD_A_CODE;
                  end else begin
                     state_next = LOAD_B;
                     load_next  = LOAD_B_CODE;
                  end
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         LOAD_A: state_next = FILL_B;
         LOAD_B: begin
            wait_next  = 4'd0;
            state_next = WAIT;
         end
         WAIT: begin
            wait_next = wait_reg + 4'd1;
            if (wait_reg == 4'(MERGE_LAT - 1)) begin
               state_next = DONE;
               mv_next    = 1'b1;
            end
         end
         DONE:    state_next = FILL_A;
         default: state_next = FILL_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= FILL_A;
         cnt_reg   <= '0;
         wait_reg  <= 4'd0;
         a_reg     <= '0;
         b_reg     <= '0;
         load_reg  <= 2'b00;
         mv_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         wait_reg  <= wait_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         load_reg  <= load_next;
         mv_reg    <= mv_next;
      end
   end

endmodule

// File: tb/tb_m_4to8_loader.sv
// Directed bench for m_4to8_loader: sorting, load order, handshake hold-off,
// merger latency, asynchronous reset abort and unsigned extremes.
module tb_m_4to8_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  load;
   logic [63:0] inba;
   logic        merged_valid;

   int total = 0;
   int bad   = 0;
   logic [1:0] load_log[$];

   m_4to8_loader #(.WIDTH(8), .N(4), .MERGE_LAT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .load         (load),
      .inba         (inba),
      .merged_valid (merged_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (load != 2'b00) load_log.push_back(load);

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a key at a negedge and hold it until accepted (bounded).
   task automatic send(input logic [7:0] k);
      int n;
      in_valid = 1'b1;
      in_data  = k;
      n = 0;
      while (!in_ready && n < 20) begin
         cyc();
         n++;
      end
      if (n == 20) chk("send_ready", {63'd0, in_ready}, 64'd1);
      cyc();
      in_valid = 1'b0;
      $display("key %0d accepted at %0t", k, $time);
   endtask

   initial begin
      logic [1:0] exp_log[7];
      exp_log = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};

      // Reset state
      #1;
      chk("rst_load", {62'd0, load}, 64'd0);
      chk("rst_inba", inba, 64'd0);
      chk("rst_mv", {63'd0, merged_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);

      // Half a, back-to-back
      send(8'd200); send(8'd0); send(8'd201); send(8'd0);
      chk("a_load01", {62'd0, load}, 64'd1);
      chk("a_ready0", {63'd0, in_ready}, 64'd0);
      chk("a_sorted", inba, {32'd0, 8'd201, 8'd200, 8'd0, 8'd0});

      // Key held through LOAD_A must be taken in FILL_B
      in_valid = 1'b1; in_data = 8'd23;
      cyc();
      chk("fb_load0", {62'd0, load}, 64'd0);
      chk("fb_ready", {63'd0, in_ready}, 64'd1);
      cyc();
      in_valid = 1'b0;
      $display("key 23 accepted at %0t", $time);
      cyc(); send(8'd9);
      cyc(); send(8'd1);
      cyc(); send(8'd1);
      chk("b_load10", {62'd0, load}, 64'd2);
      chk("b_sorted", inba, {8'd23, 8'd9, 8'd1, 8'd1, 8'd201, 8'd200, 8'd0, 8'd0});

      // Hold a key through LOAD_B/WAIT/DONE; merged_valid 2 cycles after load[1]
      in_valid = 1'b1; in_data = 8'd77;
      cyc();
      chk("wait_load", {62'd0, load}, 64'd0);
      chk("wait_mv", {63'd0, merged_valid}, 64'd0);
      chk("wait_ready", {63'd0, in_ready}, 64'd0);
      cyc();
      chk("done_mv", {63'd0, merged_valid}, 64'd1);
      chk("done_ready", {63'd0, in_ready}, 64'd0);
      chk("done_inba", inba, {8'd23, 8'd9, 8'd1, 8'd1, 8'd201, 8'd200, 8'd0, 8'd0});
      cyc();
      chk("fa_mv0", {63'd0, merged_valid}, 64'd0);
      chk("fa_ready", {63'd0, in_ready}, 64'd1);
      cyc();
      in_valid = 1'b0;
      $display("key 77 accepted at %0t", $time);
      chk("held_key", {56'd0, inba[7:0]}, 64'd77);

      send(8'd10); send(8'd90); send(8'd50);
      chk("a2_load01", {62'd0, load}, 64'd1);
      chk("a2_sorted", inba, {8'd23, 8'd9, 8'd1, 8'd1, 8'd90, 8'd77, 8'd50, 8'd10});

      // Reset mid-fill of half b
      cyc();
      send(8'd7); send(8'd3);
      #2 rst = 1'b0;
      #1;
      chk("arst_load", {62'd0, load}, 64'd0);
      chk("arst_inba", inba, 64'd0);
      chk("arst_mv", {63'd0, merged_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      chk("arst_ready", {63'd0, in_ready}, 64'd1);
      cyc(); cyc(); cyc();
      chk("arst_noload", {62'd0, load}, 64'd0);
      send(8'd5); send(8'd4); send(8'd3);
      chk("fresh_noload3", {62'd0, load}, 64'd0);
      send(8'd2);
      chk("fresh_load01", {62'd0, load}, 64'd1);
      chk("fresh_sorted", inba, {32'd0, 8'd5, 8'd4, 8'd3, 8'd2});

      cyc();
      send(8'd8); send(8'd8); send(8'd8); send(8'd8);
      chk("f3_load10", {62'd0, load}, 64'd2);
      cyc(); cyc();
      chk("f3_mv", {63'd0, merged_valid}, 64'd1);
      cyc();

      // Unsigned extremes
      send(8'd255); send(8'd255); send(8'd0); send(8'd255);
      chk("ext_load01", {62'd0, load}, 64'd1);
      chk("ext_sorted", {32'd0, inba[31:0]}, {32'd0, 8'd255, 8'd255, 8'd255, 8'd0});
      cyc();
      send(8'd1); send(8'd2); send(8'd3); send(8'd4);
      chk("ext_b_load10", {62'd0, load}, 64'd2);
      chk("ext_b_sorted", inba, {8'd4, 8'd3, 8'd2, 8'd1, 8'd255, 8'd255, 8'd255, 8'd0});
      cyc(); cyc();
      chk("ext_mv", {63'd0, merged_valid}, 64'd1);
      cyc();

      // Load pulse order over all frames
      chk("log_size", 64'(load_log.size()), 64'd7);
      for (int i = 0; i < 7; i++) begin
         if (i < load_log.size())
            chk($sformatf("log_%0d", i), {62'd0, load_log[i]}, {62'd0, exp_log[i]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
